comet2_fetch_unit: RTL and testbench

COMET2_FETCH_UNIT -- requirements
Module: comet2_fetch_unit

---
 rtl/comet2_fetch_unit.sv | 123 ++++++++++++
 tb/tb_comet2_fetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/comet2_fetch_unit.sv
// COMET2 instruction fetch unit: reads one or two program words per instruction
// and holds the decoded instruction for the decode stage until it is accepted.
module comet2_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        mclk,
    input  logic        rst_n,
    output logic        ram_re,
    output logic [15:0] ram_raddr,
    input  logic [15:0] ram_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst_word1,
    output logic [15:0] inst_word2,
    output logic        inst_len2,
    output logic        inst_illegal,
    output logic [15:0] inst_pc
);

    typedef enum logic [1:0] {
        S_FETCH1 = 2'd0,
        S_FETCH2 = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_word1;
    logic [15:0] r_word2;
    logic        r_len2;
    logic        r_illegal;
    logic [15:0] r_inst_pc;
    logic        w_op_len2;
    logic        w_op_illegal;

    // Returns {len2, illegal} for an opcode byte.
    function automatic logic [1:0] f_decode(input logic [7:0] op);
        logic [1:0] res;
        case (op)
            8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h23,
            8'h30, 8'h31, 8'h32, 8'h40, 8'h41, 8'h50, 8'h51,
            8'h52, 8'h53, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65,
            8'h66, 8'h70, 8'h80, 8'hF0:
                res = 2'b10;
            8'h00, 8'h14, 8'h24, 8'h25, 8'h26, 8'h27, 8'h34,
            8'h35, 8'h36, 8'h44, 8'h45, 8'h71, 8'h81:
                res = 2'b00;
            default:
                res = 2'b01;
        endcase
        return res;
    endfunction

    assign {w_op_len2, w_op_illegal} = f_decode(ram_rdata[15:8]);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH1: w_state_nxt = w_op_len2 ? S_FETCH2 : S_HOLD;
            S_FETCH2: w_state_nxt = S_HOLD;
            S_HOLD:   w_state_nxt = inst_ready ? S_FETCH1 : S_HOLD;
            default:  w_state_nxt = S_FETCH1;
        endcase
        // A redirect in HOLD with inst_ready high still completes the handshake.
        if (redirect) begin
            w_state_nxt = S_FETCH1;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_word1   <= 16'h0000;
            r_word2   <= 16'h0000;
            r_len2    <= 1'b0;
            r_illegal <= 1'b0;
            r_inst_pc <= 16'h0000;
        end else if (redirect) begin
            r_pc <= redirect_addr;
        end else begin
            case (r_state)
                S_FETCH1: begin
                    r_word1   <= ram_rdata;
                    r_inst_pc <= r_pc;
                    r_pc      <= r_pc + 16'd1;
                    r_len2    <= w_op_len2;
                    r_illegal <= w_op_illegal;
                    if (!w_op_len2) begin
                        r_word2 <= 16'h0000;
                    end
                end
                S_FETCH2: begin
                    r_word2 <= ram_rdata;
                    r_pc    <= r_pc + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // rst_n gates the read enable so memory is never read while reset is held.
    assign ram_re       = rst_n && (r_state != S_HOLD);
    assign ram_raddr    = r_pc;
    assign inst_valid   = (r_state == S_HOLD);
    assign inst_word1   = r_word1;
    assign inst_word2   = r_word2;
    assign inst_len2    = r_len2;
    assign inst_illegal = r_illegal;
    assign inst_pc      = r_inst_pc;

endmodule

// File: tb/tb_comet2_fetch_unit.sv
// Directed bench for comet2_fetch_unit: cycle-by-cycle vector table plus
// hand sequences for PC wrap and reset during a held instruction.
module tb_comet2_fetch_unit;

    logic        mclk;
    logic        rst_n;
    logic        ram_re;
    logic [15:0] ram_raddr;
    logic [15:0] ram_rdata;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_word1;
    logic [15:0] inst_word2;
    logic        inst_len2;
    logic        inst_illegal;
    logic [15:0] inst_pc;

    logic [15:0] mem [0:65535];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    typedef struct packed {
        logic        rd;
        logic [15:0] ra;
        logic        rdy;
        logic        re;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] w1;
        logic [15:0] w2;
        logic        len2;
        logic        ill;
        logic [15:0] ipc;
    } vec_t;

    vec_t tbl [25];

    comet2_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .mclk          (mclk),
        .rst_n         (rst_n),
        .ram_re        (ram_re),
        .ram_raddr     (ram_raddr),
        .ram_rdata     (ram_rdata),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_word1    (inst_word1),
        .inst_word2    (inst_word2),
        .inst_len2     (inst_len2),
        .inst_illegal  (inst_illegal),
        .inst_pc       (inst_pc)
    );

    assign ram_rdata = mem[ram_raddr];

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_outs(input vec_t v);
        chk("ram_re", {15'd0, ram_re}, {15'd0, v.re});
        chk("ram_raddr", ram_raddr, v.addr);
        chk("inst_valid", {15'd0, inst_valid}, {15'd0, v.vld});
        chk("inst_word1", inst_word1, v.w1);
        chk("inst_word2", inst_word2, v.w2);
        chk("inst_len2", {15'd0, inst_len2}, {15'd0, v.len2});
        chk("inst_illegal", {15'd0, inst_illegal}, {15'd0, v.ill});
        chk("inst_pc", inst_pc, v.ipc);
    endtask

    // Called at a negedge: drive inputs, check, then advance one clock.
    task automatic step(input vec_t v);
        redirect      = v.rd;
        redirect_addr = v.ra;
        inst_ready    = v.rdy;
        #1;
        chk_outs(v);
        @(posedge mclk);
        @(negedge mclk);
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h1260;
        mem[16'h0001] = 16'h0050;
        mem[16'h0002] = 16'h7100;
        mem[16'h0003] = 16'h9900;
        mem[16'h0004] = 16'h6400;
        mem[16'h0005] = 16'h1234;
        mem[16'h000C] = 16'h7100;
        mem[16'h000D] = 16'h7100;
        mem[16'h0010] = 16'h8006;
        mem[16'h0011] = 16'h0000;
        mem[16'h0050] = 16'h2610;
        mem[16'hFFFF] = 16'h1210;

        //            rd  ra        rdy  re  addr      vld  w1        w2        len  ill  ipc
        tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h1260, 16'h0000, 1'b1, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b1, 16'h1260, 16'h0050, 1'b1, 1'b0, 16'h0000};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h1260, 16'h0050, 1'b1, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0003, 1'b1, 16'h7100, 16'h0000, 1'b0, 1'b0, 16'h0002};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 1'b1, 16'h7100, 16'h0000, 1'b0, 1'b0, 16'h0002};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 1'b0, 16'h7100, 16'h0000, 1'b0, 1'b0, 16'h0002};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 1'b1, 16'h9900, 16'h0000, 1'b0, 1'b1, 16'h0003};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h9900, 16'h0000, 1'b0, 1'b1, 16'h0003};
        tbl[9]  = '{1'b1, 16'h0050, 1'b1, 1'b1, 16'h0005, 1'b0, 16'h6400, 16'h0000, 1'b1, 1'b0, 16'h0004};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0050, 1'b0, 16'h6400, 16'h0000, 1'b1, 1'b0, 16'h0004};
        tbl[11] = '{1'b1, 16'h000C, 1'b1, 1'b0, 16'h0051, 1'b1, 16'h2610, 16'h0000, 1'b0, 1'b0, 16'h0050};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C, 1'b0, 16'h2610, 16'h0000, 1'b0, 1'b0, 16'h0050};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h000D, 1'b1, 16'h7100, 16'h0000, 1'b0, 1'b0, 16'h000C};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h000D, 1'b0, 16'h7100, 16'h0000, 1'b0, 1'b0, 16'h000C};
        tbl[15] = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h000E, 1'b1, 16'h7100, 16'h0000, 1'b0, 1'b0, 16'h000D};
        tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h7100, 16'h0000, 1'b0, 1'b0, 16'h000D};
        tbl[17] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0011, 1'b0, 16'h8006, 16'h0000, 1'b1, 1'b0, 16'h0010};
        for (int i = 18; i < 23; i++)
            tbl[i] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0012, 1'b1, 16'h8006, 16'h0000, 1'b1, 1'b0, 16'h0010};
        tbl[23] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 1'b1, 16'h8006, 16'h0000, 1'b1, 1'b0, 16'h0010};
        tbl[24] = '{1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h0012, 1'b0, 16'h8006, 16'h0000, 1'b1, 1'b0, 16'h0010};

        rst_n         = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 16'h0000;
        inst_ready    = 1'b0;
        @(posedge mclk);
        @(negedge mclk);
        chk_outs('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000});
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) step(tbl[i]);

        // PC wrap between word1 and word2; new contents at 0000 for this part.
        mem[16'h0000] = 16'h5A5A;
        step('{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h8006, 16'h0000, 1'b1, 1'b0, 16'h0010});
        step('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h1210, 16'h0000, 1'b1, 1'b0, 16'hFFFF});
        redirect   = 1'b0;
        inst_ready = 1'b0;
        #1;
        chk_outs('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 16'h1210, 16'h5A5A, 1'b1, 1'b0, 16'hFFFF});

        // Asynchronous reset while holding: everything clears without a clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk_outs('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000});
        @(negedge mclk);
        rst_n = 1'b1;
        cyc = 100;
        step('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000});
        step('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 16'h5A5A, 16'h0000, 1'b0, 1'b1, 16'h0000});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
